// File: rtl/tf_bus_pkg.sv
// tf_bus_pkg: shared state encoding, SIZ codes and lane helpers for the
// 68030-style bus master.
package tf_bus_pkg;

  // Bus master sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    STRB = 3'd2,
    WAIT = 3'd3,
    TERM = 3'd4,
    DONE = 3'd5
  } bus_state_e;

  // 68030 SIZ pin coding
  localparam logic [1:0] SIZ_LONG = 2'd0;
  localparam logic [1:0] SIZ_BYTE = 2'd1;
  localparam logic [1:0] SIZ_WORD = 2'd2;

  // Byte transfers keep the exact byte address; word and long transfers are
  // always issued on an even address because the low bit carries no meaning.
  function automatic logic [31:0] alignAddr(input logic [31:0] addr,
                                            input logic [1:0]  siz);
    logic [31:0] aligned;
    if (siz == SIZ_BYTE) begin
      aligned = addr;
    end else begin
      aligned = {addr[31:1], 1'b0};
    end
    return aligned;
  endfunction

  // Data presented on the 16-bit bus for one bus cycle. Bytes go out on both
  // lanes so the slave can pick whichever lane A[0] selects; a long sends its
  // upper word first.
  function automatic logic [15:0] laneWriteData(input logic [1:0]  siz,
                                                input logic        secondHalf,
                                                input logic [31:0] wdata);
    logic [15:0] lanes;
    case (siz)
      SIZ_BYTE: lanes = {wdata[7:0], wdata[7:0]};
      SIZ_LONG: lanes = secondHalf ? wdata[15:0] : wdata[31:16];
      default:  lanes = wdata[15:0];
    endcase
    return lanes;
  endfunction

  // Right-justified read result after capturing one bus word. An even byte
  // address reads the upper lane, an odd one the lower lane. For a long the
  // first capture lands in the upper half and the second keeps it.
  function automatic logic [31:0] mergeReadData(input logic [1:0]  siz,
                                                input logic        secondHalf,
                                                input logic        addrLsb,
                                                input logic [15:0] din,
                                                input logic [15:0] prevUpper);
    logic [31:0] merged;
    case (siz)
      SIZ_BYTE: merged = {24'h000000, (addrLsb ? din[7:0] : din[15:8])};
      SIZ_LONG: merged = secondHalf ? {prevUpper, din} : {din, 16'h0000};
      default:  merged = {16'h0000, din};
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: plain flop chain for bringing an asynchronous signal into the
// local clock domain. Resets to RESET_VALUE so active-low inputs start idle.
module sync_ff #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the raw input through DEPTH flops; only the last one is used
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: turns single request/response transfers into 68030-style
// bus cycles on a 16-bit data bus. Longs are split into two word cycles and a
// slave that never terminates is abandoned after TIMEOUT wait cycles.
module cpu_bus_master
  import tf_bus_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int DTACK_SYNC = 2
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_rw,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] A,
  output logic [1:0]  SIZ,
  output logic        RW20,
  output logic        AS20,
  output logic        DS20,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [15:0] D_IN,
  input  logic        STERM,
  input  logic        DTACK
);

  localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_e       state_q, state_d;
  logic [1:0]       reqSize_q, reqSize_d;
  logic [31:0]      reqWdata_q, reqWdata_d;
  logic             secondHalf_q, secondHalf_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [31:0]      busAddr_q, busAddr_d;
  logic [1:0]       busSiz_q, busSiz_d;
  logic             busRw_q, busRw_d;
  logic [15:0]      dOut_q, dOut_d;
  logic [31:0]      rdata_q, rdata_d;

  logic dtackSync;
  logic termSeen;
  logic waitExpired;
  logic acceptReq;
  logic longPending;

  sync_ff #(
    .WIDTH      (1),
    .DEPTH      (DTACK_SYNC),
    .RESET_VALUE(1'b1)
  ) u_dtackSync (
    .clk_i(CLKCPU),
    .rst_i(RESET),
    .d_i  (DTACK),
    .q_o  (dtackSync)
  );

  // STERM is already synchronous; DTACK only counts once it has cleared the
  // synchroniser. Both low together is still a single termination.
  assign termSeen    = !STERM || !dtackSync;
  assign waitExpired = (waitCnt_q == WAIT_LAST);
  assign acceptReq   = (state_q == IDLE) && req_valid;
  assign longPending = (reqSize_q == SIZ_LONG) && !secondHalf_q && !err_q;

  // State register
  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: terminations are only looked at in WAIT, so anything
  // arriving during ADDR or STRB is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ADDR;
        end
      end
      ADDR: state_d = STRB;
      STRB: state_d = WAIT;
      WAIT: begin
        if (termSeen || waitExpired) begin
          state_d = TERM;
        end
      end
      TERM: begin
        if (longPending) begin
          state_d = ADDR;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe, handshake and drive-enable outputs decoded from the state. Reads
  // assert DS20 together with AS20; writes hold DS20 back until WAIT so the
  // data has settled. D_OE covers ADDR through TERM of a write.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    AS20       = 1'b1;
    DS20       = 1'b1;
    D_OE       = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      ADDR: D_OE = !busRw_q;
      STRB: begin
        AS20 = 1'b0;
        DS20 = !busRw_q;
        D_OE = !busRw_q;
      end
      WAIT: begin
        AS20 = 1'b0;
        DS20 = 1'b0;
        D_OE = !busRw_q;
      end
      TERM: D_OE = !busRw_q;
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
      end
      default: begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
      end
    endcase
  end

  // Datapath next values: latch the request on accept, step to the second
  // word of a long, count wait states and capture read data on termination
  always_comb begin
    reqSize_d    = reqSize_q;
    reqWdata_d   = reqWdata_q;
    secondHalf_d = secondHalf_q;
    err_d        = err_q;
    waitCnt_d    = waitCnt_q;
    busAddr_d    = busAddr_q;
    busSiz_d     = busSiz_q;
    busRw_d      = busRw_q;
    dOut_d       = dOut_q;
    rdata_d      = rdata_q;

    if (acceptReq) begin
      reqSize_d    = req_size;
      reqWdata_d   = req_wdata;
      secondHalf_d = 1'b0;
      err_d        = 1'b0;
      busAddr_d    = alignAddr(req_addr, req_size);
      busSiz_d     = req_size;
      busRw_d      = req_rw;
      dOut_d       = laneWriteData(req_size, 1'b0, req_wdata);
    end

    if (state_q == STRB) begin
      waitCnt_d = '0;
    end

    if (state_q == WAIT) begin
      waitCnt_d = waitCnt_q + 1'b1;
      if (termSeen) begin
        if (busRw_q) begin
          rdata_d = mergeReadData(reqSize_q, secondHalf_q, busAddr_q[0],
                                  D_IN, rdata_q[31:16]);
        end
      end else if (waitExpired) begin
        err_d = 1'b1;
      end
    end

    // The address wraps naturally at 32 bits when the long straddles the top
    if ((state_q == TERM) && longPending) begin
      secondHalf_d = 1'b1;
      busAddr_d    = busAddr_q + 32'd2;
      busSiz_d     = SIZ_WORD;
      dOut_d       = laneWriteData(SIZ_LONG, 1'b1, reqWdata_q);
    end
  end

  // Datapath registers; bus direction idles as read
  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      reqSize_q    <= SIZ_LONG;
      reqWdata_q   <= '0;
      secondHalf_q <= 1'b0;
      err_q        <= 1'b0;
      waitCnt_q    <= '0;
      busAddr_q    <= '0;
      busSiz_q     <= 2'b00;
      busRw_q      <= 1'b1;
      dOut_q       <= '0;
      rdata_q      <= '0;
    end else begin
      reqSize_q    <= reqSize_d;
      reqWdata_q   <= reqWdata_d;
      secondHalf_q <= secondHalf_d;
      err_q        <= err_d;
      waitCnt_q    <= waitCnt_d;
      busAddr_q    <= busAddr_d;
      busSiz_q     <= busSiz_d;
      busRw_q      <= busRw_d;
      dOut_q       <= dOut_d;
      rdata_q      <= rdata_d;
    end
  end

  assign A          = busAddr_q;
  assign SIZ        = busSiz_q;
  assign RW20       = busRw_q;
  assign D_OUT      = dOut_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: directed and randomised transfers against a bus slave
// model, with every bus cycle and response checked against expectations
// derived from the transfer request.
module tb_cpu_bus_master;

  localparam int TIMEOUT    = 64;
  localparam int DTACK_SYNC = 2;

  localparam int MODE_STERM = 0;
  localparam int MODE_DTACK = 1;
  localparam int MODE_NONE  = 2;

  logic        CLKCPU = 1'b0;
  logic        RESET  = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr  = '0;
  logic [1:0]  req_size  = '0;
  logic        req_rw    = 1'b1;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] A;
  logic [1:0]  SIZ;
  logic        RW20;
  logic        AS20;
  logic        DS20;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic [15:0] D_IN  = '0;
  logic        STERM = 1'b1;
  logic        DTACK = 1'b1;

  // One observed bus cycle (one AS20-low window)
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  siz;
    logic        rw;
    logic [15:0] dout;
    logic [15:0] din;
    logic        oeStart;
    logic [31:0] addrTerm;
    logic [1:0]  sizTerm;
    logic        oeTerm;
    int          asCnt;
    int          dsCnt;
  } busCycle_t;

  busCycle_t   busLog[$];
  int          termMode  = MODE_NONE;
  int          termAfter = 0;
  bit          forceDin  = 1'b0;
  logic [15:0] forcedDin = '0;
  logic [31:0] lastRdata;
  logic        lastErr;
  int          assertCount = 0;
  int          failCount   = 0;

  always #5 CLKCPU = ~CLKCPU;

  cpu_bus_master #(
    .TIMEOUT   (TIMEOUT),
    .DTACK_SYNC(DTACK_SYNC)
  ) dut (
    .CLKCPU    (CLKCPU),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .A         (A),
    .SIZ       (SIZ),
    .RW20      (RW20),
    .AS20      (AS20),
    .DS20      (DS20),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
    .D_IN      (D_IN),
    .STERM     (STERM),
    .DTACK     (DTACK)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Slave model: logs each AS20-low window and terminates it with STERM or
  // DTACK once the strobe has been seen termAfter+1 times, or never
  initial begin : busSlave
    busCycle_t cur;
    bit        inCycle;
    inCycle = 1'b0;
    cur = '{default: '0};
    forever begin
      @(negedge CLKCPU);
      if (RESET) begin
        inCycle = 1'b0;
        STERM   = 1'b1;
        DTACK   = 1'b1;
      end else if (AS20 === 1'b0) begin
        if (!inCycle) begin
          inCycle     = 1'b1;
          cur.addr    = A;
          cur.siz     = SIZ;
          cur.rw      = RW20;
          cur.dout    = D_OUT;
          cur.oeStart = D_OE;
          cur.din     = forceDin ? forcedDin : 16'($urandom);
          cur.asCnt   = 0;
          cur.dsCnt   = 0;
          D_IN        = cur.din;
        end
        cur.asCnt++;
        if (DS20 === 1'b0) cur.dsCnt++;
        if (termMode == MODE_STERM && cur.asCnt == termAfter + 1) STERM = 1'b0;
        if (termMode == MODE_DTACK && cur.asCnt == termAfter + 1) DTACK = 1'b0;
      end else if (inCycle) begin
        inCycle      = 1'b0;
        STERM        = 1'b1;
        DTACK        = 1'b1;
        cur.addrTerm = A;
        cur.sizTerm  = SIZ;
        cur.oeTerm   = D_OE;
        busLog.push_back(cur);
      end
    end
  end

  // Run one transfer and compare every bus cycle and the response against a
  // model derived from the request alone
  task automatic applyStimulus(input logic rw, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int mode, input int after, input int expLatency);
    int          cyc;
    int          nExp;
    int          expAs;
    bit          gotResp;
    logic [31:0] baseAddr;
    logic [31:0] expAddr;
    logic [1:0]  expSiz;
    logic [15:0] expDout;
    logic [31:0] expRdata;
    logic        expErr;

    busLog.delete();
    termMode  = mode;
    termAfter = after;
    lastRdata = '0;
    lastErr   = 1'b0;

    @(posedge CLKCPU); #1;
    req_valid = 1'b1;
    req_rw    = rw;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    cyc = 0;
    @(negedge CLKCPU);
    while (req_ready !== 1'b1 && cyc < 10) begin
      @(negedge CLKCPU);
      cyc++;
    end
    checkOutput("req_ready", req_ready, 1);
    @(posedge CLKCPU); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_rw    = 1'($urandom_range(0, 1));
    req_size  = 2'($urandom_range(0, 2));

    cyc = 0;
    gotResp = 1'b0;
    while (!gotResp && cyc < 2 * TIMEOUT + 40) begin
      @(negedge CLKCPU);
      cyc++;
      if (resp_valid === 1'b1) begin
        gotResp   = 1'b1;
        lastRdata = resp_rdata;
        lastErr   = resp_err;
        checkOutput("d_oe_in_done", D_OE, 0);
      end
    end
    checkOutput("resp_seen", gotResp, 1);
    if (expLatency >= 0) checkOutput("latency", cyc, expLatency);
    @(negedge CLKCPU);
    checkOutput("resp_one_cycle", resp_valid, 0);
    checkOutput("ready_after_done", req_ready, 1);

    nExp     = (size == 2'd0 && mode != MODE_NONE) ? 2 : 1;
    baseAddr = (size == 2'd1) ? addr : {addr[31:1], 1'b0};
    if (mode == MODE_STERM)      expAs = 1 + ((after < 1) ? 1 : after);
    else if (mode == MODE_DTACK) expAs = after + 1 + DTACK_SYNC;
    else                         expAs = TIMEOUT + 1;
    expErr = (mode == MODE_NONE);

    checkOutput("bus_cycles", busLog.size(), nExp);
    for (int k = 0; k < busLog.size() && k < nExp; k++) begin
      expAddr = baseAddr + 32'(2 * k);
      expSiz  = (size == 2'd0) ? ((k == 0) ? 2'd0 : 2'd2) : size;
      checkOutput("bus_addr", busLog[k].addr, expAddr);
      checkOutput("bus_addr_term", busLog[k].addrTerm, expAddr);
      checkOutput("bus_siz", busLog[k].siz, expSiz);
      checkOutput("bus_siz_term", busLog[k].sizTerm, expSiz);
      checkOutput("bus_rw", busLog[k].rw, rw);
      checkOutput("as_cycles", busLog[k].asCnt, expAs);
      checkOutput("ds_cycles", busLog[k].dsCnt, rw ? expAs : expAs - 1);
      checkOutput("d_oe_strobe", busLog[k].oeStart, !rw);
      checkOutput("d_oe_term", busLog[k].oeTerm, !rw);
      if (!rw) begin
        if (size == 2'd1)      expDout = {wdata[7:0], wdata[7:0]};
        else if (size == 2'd0) expDout = (k == 0) ? wdata[31:16] : wdata[15:0];
        else                   expDout = wdata[15:0];
        checkOutput("bus_dout", busLog[k].dout, expDout);
      end
    end

    checkOutput("resp_err", lastErr, expErr);
    if (rw && !expErr && busLog.size() == nExp) begin
      if (size == 2'd1)
        expRdata = {24'h0, (addr[0] ? busLog[0].din[7:0] : busLog[0].din[15:8])};
      else if (size == 2'd0)
        expRdata = {busLog[0].din, busLog[1].din};
      else
        expRdata = {16'h0, busLog[0].din};
      checkOutput("resp_rdata", lastRdata, expRdata);
    end
  endtask

  initial begin : mainSequence
    int          cyc;
    int          respCount;
    logic        rRw;
    logic [1:0]  rSize;
    logic [31:0] rAddr;
    int          rMode;

    // Reset state
    RESET = 1'b1;
    repeat (3) @(posedge CLKCPU);
    @(negedge CLKCPU);
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_as20", AS20, 1);
    checkOutput("rst_ds20", DS20, 1);
    checkOutput("rst_rw20", RW20, 1);
    checkOutput("rst_d_oe", D_OE, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_a", A, 0);
    checkOutput("rst_siz", SIZ, 0);
    checkOutput("rst_d_out", D_OUT, 0);
    checkOutput("rst_rdata", resp_rdata, 0);
    @(posedge CLKCPU); #1;
    RESET = 1'b0;

    $display("[TB] word read, zero wait states");
    forceDin  = 1'b1;
    forcedDin = 16'h1234;
    applyStimulus(1'b1, 2'd2, 32'h00F0_0000, 32'h0, MODE_STERM, 0, 5);
    checkOutput("word_read_rdata", lastRdata, 32'h0000_1234);
    checkOutput("word_read_err", lastErr, 0);

    $display("[TB] long write split into two words");
    forceDin = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h0020_0000, 32'h1234_5678, MODE_STERM, 0, -1);
    if (busLog.size() == 2) begin
      checkOutput("long_wr_first_dout", busLog[0].dout, 32'h1234);
      checkOutput("long_wr_second_addr", busLog[1].addr, 32'h0020_0002);
      checkOutput("long_wr_second_dout", busLog[1].dout, 32'h5678);
    end

    $display("[TB] byte read on odd address via DTACK");
    forceDin  = 1'b1;
    forcedDin = 16'hAA55;
    applyStimulus(1'b1, 2'd1, 32'h0000_1001, 32'h0, MODE_DTACK, 3, -1);
    checkOutput("byte_read_rdata", lastRdata, 32'h0000_0055);
    checkOutput("byte_read_err", lastErr, 0);
    applyStimulus(1'b1, 2'd1, 32'h0000_1000, 32'h0, MODE_STERM, 2, -1);
    checkOutput("byte_read_even_rdata", lastRdata, 32'h0000_00AA);
    forceDin = 1'b0;

    $display("[TB] word read with no termination");
    applyStimulus(1'b1, 2'd2, 32'h0040_0000, 32'h0, MODE_NONE, 0, -1);
    checkOutput("timeout_err", lastErr, 1);

    $display("[TB] long read wrapping the address space");
    applyStimulus(1'b1, 2'd0, 32'hFFFF_FFFE, 32'h0, MODE_STERM, 1, -1);
    if (busLog.size() == 2) begin
      checkOutput("wrap_second_addr", busLog[1].addr, 32'h0000_0000);
    end

    $display("[TB] byte write replication and long timeout");
    applyStimulus(1'b0, 2'd1, 32'h0000_2003, 32'hCAFE_BEC3, MODE_DTACK, 0, -1);
    applyStimulus(1'b0, 2'd0, 32'h0000_3000, 32'hDEAD_BEEF, MODE_NONE, 0, -1);

    $display("[TB] reset during WAIT of a long write");
    busLog.delete();
    termMode = MODE_NONE;
    @(posedge CLKCPU); #1;
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_size  = 2'd0;
    req_addr  = 32'h0030_0000;
    req_wdata = 32'hA5A5_5A5A;
    @(posedge CLKCPU); #1;
    req_valid = 1'b0;
    cyc = 0;
    @(negedge CLKCPU);
    while (AS20 !== 1'b0 && cyc < 10) begin
      @(negedge CLKCPU);
      cyc++;
    end
    checkOutput("rst_mid_strobe_seen", AS20, 0);
    repeat (3) @(negedge CLKCPU);
    @(posedge CLKCPU); #1;
    RESET = 1'b1;
    @(posedge CLKCPU);
    @(negedge CLKCPU);
    checkOutput("rst_mid_as20", AS20, 1);
    checkOutput("rst_mid_ds20", DS20, 1);
    checkOutput("rst_mid_d_oe", D_OE, 0);
    checkOutput("rst_mid_resp_valid", resp_valid, 0);
    checkOutput("rst_mid_idle", req_ready, 1);
    checkOutput("rst_mid_a", A, 0);
    checkOutput("rst_mid_d_out", D_OUT, 0);
    @(posedge CLKCPU); #1;
    RESET = 1'b0;
    respCount = 0;
    repeat (2 * TIMEOUT) begin
      @(negedge CLKCPU);
      if (resp_valid === 1'b1) respCount++;
    end
    checkOutput("rst_mid_no_resp", respCount, 0);
    checkOutput("rst_mid_no_bus", busLog.size(), 0);

    $display("[TB] randomised transfers");
    for (int t = 0; t < 24; t++) begin
      rRw   = 1'($urandom_range(0, 1));
      rSize = 2'($urandom_range(0, 2));
      rAddr = $urandom;
      if ($urandom_range(0, 4) == 0) rAddr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      rMode = ($urandom_range(0, 9) == 9) ? MODE_NONE : int'($urandom_range(0, 1));
      applyStimulus(rRw, rSize, rAddr, $urandom, rMode, int'($urandom_range(0, 6)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, wait-state cycles before the cycle is aborted with error.
REQ-002 SHALL have parameter DTACK_SYNC, default 2, number of synchroniser flops on DTACK.
REQ-003 SHALL have port CLKCPU  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  1  transfer request.
REQ-006 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_addr  in  32  byte address, bit 0 ignored for word/long.
REQ-008 SHALL have port req_size  in  2  1=byte, 2=word, 0=long (68030 SIZ coding).
REQ-009 SHALL have port req_rw  in  1  1=read, 0=write.
REQ-010 SHALL have port req_wdata  in  32  write data, right-justified.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32  read data, right-justified, valid with resp_valid.
REQ-013 SHALL have port resp_err  out  1  timeout flag, valid with resp_valid.
REQ-014 SHALL have port A  out  32  bus address.
REQ-015 SHALL have port SIZ  out  2  bus size.
REQ-016 SHALL have port RW20  out  1  bus direction, 1=read.
REQ-017 SHALL have port AS20  out  1  address strobe, active low.
REQ-018 SHALL have port DS20  out  1  data strobe, active low.
REQ-019 SHALL have port D_OUT  out  16  write data to bus.
REQ-020 SHALL have port D_OE  out  1  D_OUT drive enable.
REQ-021 SHALL have port D_IN  in  16  read data from bus.
REQ-022 SHALL have port STERM  in  1  synchronous termination, active low, already CLKCPU-synchronous.
REQ-023 SHALL have port DTACK  in  1  asynchronous termination, active low.

Function
REQ-024 SHALL implement states IDLE, ADDR, STRB, WAIT, TERM, DONE.
REQ-025 IDLE: req_ready=1; req_valid high SHALL latch request and enter ADDR next cycle; req_ready low in all other states.
REQ-026 ADDR: SHALL drive A, SIZ, RW20 with AS20/DS20 high; writes SHALL assert D_OE and D_OUT this cycle.
REQ-027 STRB: SHALL assert AS20 low; reads SHALL assert DS20 low in the same cycle; writes SHALL assert DS20 one cycle later (entering WAIT).
REQ-028 WAIT: each cycle SHALL test STERM low or synchronised DTACK low; either SHALL capture D_IN (reads) and enter TERM.
REQ-029 STERM and DTACK low in the same cycle SHALL be treated as one termination.
REQ-030 TERM: AS20, DS20 SHALL go high; D_OE SHALL drop one cycle after TERM; A/SIZ/RW20 held through TERM.
REQ-031 Byte: 16-bit lane selection by A[0]: A[0]=0 uses D[15:8], A[0]=1 uses D[7:0]; writes SHALL replicate byte on both lanes.
REQ-032 Long: SHALL issue two word cycles; first SIZ=0 at addr, second SIZ=2 at addr+2; first word is bits 31:16.
REQ-033 Between halves of a long SHALL pass TERM -> ADDR, AS20 high at least one cycle.
REQ-034 Address increment SHALL be 32-bit modulo; 0xFFFFFFFE+2 wraps to 0x00000000.
REQ-035 Wait counter SHALL reset on entering WAIT; reaching TIMEOUT SHALL enter TERM, set error, abandon any remaining long half.
REQ-036 DONE: resp_valid=1 for exactly one cycle, resp_err per REQ-035, then IDLE; earliest new accept is the cycle after DONE.
REQ-037 Bus cycle latency, zero wait states, word read: req accept to resp_valid = 5 cycles.
REQ-038 Termination arriving in ADDR or STRB SHALL be ignored.

Reset
REQ-039 RESET high SHALL force IDLE, AS20=DS20=1, RW20=1, D_OE=0, resp_valid=0, resp_err=0, counters and synchroniser to idle (high), mid-cycle included.
REQ-040 A, SIZ, D_OUT, resp_rdata SHALL reset to 0.

Structure
REQ-041 State encoding, SIZ constants (SIZ_LONG, SIZ_BYTE, SIZ_WORD) SHALL live in shared package tf_bus_pkg.
REQ-042 DTACK synchroniser SHALL be sub-module sync_ff (width 1, depth DTACK_SYNC).

Verification
REQ-043 Word read 0x00F00000, STERM low first WAIT cycle, D_IN=0x1234 -> resp_rdata=0x00001234, err=0, resp 5 cycles after accept.
REQ-044 Long write 0x12345678 to 0x200000 -> two cycles: SIZ=0 A=0x200000 D_OUT=0x1234, then SIZ=2 A=0x200002 D_OUT=0x5678, AS20 high between.
REQ-045 Byte read 0x1001, DTACK low after 3 wait cycles, D_IN=0xAA55 -> resp_rdata=0x00000055, err=0.
REQ-046 Word read, no termination -> resp_err=1 after TIMEOUT=64 WAIT cycles, AS20 high next cycle.
REQ-047 RESET asserted in WAIT of a long write -> next cycle AS20=DS20=1, D_OE=0, IDLE, no resp_valid.
REQ-048 Long read at 0xFFFFFFFE -> second half A=0x00000000.
